// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, rotate mode encodings and
// the state type of the multi-cycle rotate unit.
package alu_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  localparam logic MODE_ROR = 1'b0;
  localparam logic MODE_ROL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rot_state_t;

endpackage

// File: rtl/seq_rotator_rot1_step.sv
// Combinational single-position rotator; one instance feeds the data
// register of seq_rotator, so each clock advances the rotation by one bit.
module rot1_step #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);
  import alu_pkg::*;

  assign q = (dir == MODE_ROL) ? {d[WIDTH-2:0], d[WIDTH-1]}
                               : {d[0], d[WIDTH-1:1]};

endmodule

// File: rtl/seq_rotator.sv
// Multi-cycle rotate unit: ROR/ROL one bit per clock under a
// start/busy/done handshake; the result is held until the next accepted start.
module seq_rotator #(
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Rot_In,
  input  logic [SHAMT_W-1:0] Rot_Val,
  input  logic               Mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Rot_Out
);
  import alu_pkg::*;

  rot_state_t         state, state_next;
  logic [WIDTH-1:0]   data, data_next;
  logic [SHAMT_W-1:0] count, count_next;
  logic               mode, mode_next;
  logic [WIDTH-1:0]   data_rot;

  rot1_step #(.WIDTH(WIDTH)) u_rot1_step (
    .d   (data),
    .dir (mode),
    .q   (data_rot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
      mode  <= MODE_ROR;
    end else begin
      state <= state_next;
      data  <= data_next;
      count <= count_next;
      mode  <= mode_next;
    end
  end

  // Requests are only accepted in IDLE, so a start during RUN or DONE
  // leaves every register untouched.
  always_comb begin
    state_next = state;
    data_next  = data;
    count_next = count;
    mode_next  = mode;
    case (state)
      IDLE: begin
        if (start) begin
          data_next  = Rot_In;
          count_next = Rot_Val;
          mode_next  = Mode;
          state_next = (Rot_Val == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        data_next  = data_rot;
        count_next = count - SHAMT_W'(1);
        if (count == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign Rot_Out = data;

endmodule

// File: tb/tb_seq_rotator.sv
// Testbench for seq_rotator: table of rotate requests checked through a
// scoreboard queue, plus hand-written ignored-start, back-to-back and reset sequences.
module tb_seq_rotator;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] rot_in;
  logic [3:0]  rot_val;
  logic        mode_in;
  logic        busy;
  logic        done;
  logic [15:0] rot_out;

  int          vec_count   = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [3:0]  amount;
    logic        mode;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_rotator dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .Rot_In  (rot_in),
    .Rot_Val (rot_val),
    .Mode    (mode_in),
    .busy    (busy),
    .done    (done),
    .Rot_Out (rot_out)
  );

  // Reference rotate: slice a doubled word; ROL by n is ROR by (16-n) mod 16.
  function automatic logic [15:0] model_rot(input logic [15:0] d, input int n, input logic m);
    logic [31:0] dd;
    int          r;
    dd = {d, d};
    r  = m ? ((16 - n) % 16) : n;
    return dd[r +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one start cycle; afterwards the inputs are scrambled since only
  // the latched copies may matter.
  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] v, input logic m);
    start   = 1'b1;
    rot_in  = d;
    rot_val = v;
    mode_in = m;
    tick();
    start   = 1'b0;
    rot_in  = 16'($urandom);
    rot_val = 4'($urandom);
    mode_in = 1'($urandom);
  endtask

  task automatic wait_done(input string name, input int start_cyc, input int exp_cyc);
    int          cyc;
    logic        busy_bad;
    logic [15:0] e;
    cyc      = start_cyc;
    busy_bad = 1'b0;
    while (!done && cyc < exp_cyc + 4) begin
      if (!busy) busy_bad = 1'b1;
      tick();
      cyc++;
    end
    check_output({name, " done"}, 32'(done), 32'd1);
    check_output({name, " done cycle"}, 32'(cyc), 32'(exp_cyc));
    check_output({name, " busy while running"}, 32'(busy_bad), 32'd0);
    check_output({name, " busy at done"}, 32'(busy), 32'd1);
    if (exp_q.size() == 0) begin
      check_output({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_output({name, " Rot_Out"}, 32'(rot_out), 32'(e));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout: got no end, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic        saw_done;
    logic [15:0] d;
    logic [3:0]  v;
    logic        m;

    vecs.push_back('{"ror 0x1234 by 4", 16'h1234, 4'd4,  MODE_ROR, 16'h4123});
    vecs.push_back('{"rol 0x8001 by 1", 16'h8001, 4'd1,  MODE_ROL, 16'h0003});
    vecs.push_back('{"zero amount",     16'hBEEF, 4'd0,  MODE_ROR, 16'hBEEF});
    vecs.push_back('{"ror 0x8000 by 15",16'h8000, 4'd15, MODE_ROR, 16'h0001});
    vecs.push_back('{"rol 0x8000 by 15",16'h8000, 4'd15, MODE_ROL, 16'h4000});
    vecs.push_back('{"rol 0x1234 by 8", 16'h1234, 4'd8,  MODE_ROL, 16'h3412});
    vecs.push_back('{"zero amount rol", 16'h0F0F, 4'd0,  MODE_ROL, 16'h0F0F});
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      v = 4'($urandom);
      m = 1'($urandom);
      vecs.push_back('{$sformatf("random %0d", i), d, v, m, model_rot(d, int'(v), m)});
    end

    rst = 1'b1; start = 1'b0; rot_in = '0; rot_val = '0; mode_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset Rot_Out", 32'(rot_out), 32'd0);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].expected);
      apply_stimulus(vecs[i].data, vecs[i].amount, vecs[i].mode);
      wait_done(vecs[i].name, 1, int'(vecs[i].amount) + 1);
      tick();
      tick();
      check_output({vecs[i].name, " idle after done"}, {30'd0, busy, done}, 32'd0);
      check_output({vecs[i].name, " result held"}, 32'(rot_out), 32'(vecs[i].expected));
    end

    // Maximum amount; a start pulse in cycle 6 must be ignored.
    exp_q.push_back(16'h0002);
    apply_stimulus(16'h0001, 4'd15, MODE_ROR);
    repeat (5) tick();
    start = 1'b1; rot_in = 16'hFFFF; rot_val = 4'd2; mode_in = MODE_ROR;
    tick();
    start = 1'b0;
    wait_done("ignored start", 7, 16);
    tick();
    check_output("ignored start no restart", 32'(busy), 32'd0);

    // Back-to-back with start held high: the DONE-cycle start is ignored.
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h000F);
    start = 1'b1; rot_in = 16'h00F0; rot_val = 4'd4; mode_in = MODE_ROL;
    tick();
    rot_in = 16'h0F00; rot_val = 4'd8; mode_in = MODE_ROR;
    wait_done("b2b first", 1, 5);
    tick();
    check_output("b2b idle in cycle 6", 32'(busy), 32'd0);
    check_output("b2b first result held", 32'(rot_out), 32'h0F00);
    tick();
    start = 1'b0;
    wait_done("b2b second", 7, 15);

    // Reset in cycle 3 of a 10-step rotate aborts it silently.
    tick();
    apply_stimulus(16'h1234, 4'd10, MODE_ROL);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort done", 32'(done), 32'd0);
    check_output("abort Rot_Out", 32'(rot_out), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      saw_done |= done | busy;
      tick();
    end
    check_output("abort no later done", 32'(saw_done), 32'd0);
    exp_q.push_back(16'hA5A5);
    apply_stimulus(16'hA5A5, 4'd8, MODE_ROR);
    wait_done("after abort", 1, 9);
    tick();

    // Reset and start together: reset wins and the request is dropped.
    check_output("pre-collision Rot_Out", 32'(rot_out), 32'hA5A5);
    rst = 1'b1; start = 1'b1; rot_in = 16'h1111; rot_val = 4'd3; mode_in = MODE_ROL;
    tick();
    rst = 1'b0; start = 1'b0;
    check_output("collision busy", 32'(busy), 32'd0);
    check_output("collision Rot_Out", 32'(rot_out), 32'd0);
    tick();
    tick();
    check_output("collision still idle", {30'd0, busy, done}, 32'd0);

    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
